// File: rtl/slurm32_memory_arbiter.sv
// Arbitrates instruction fetches and data loads/stores onto one shared memory port.
// One port transaction is outstanding at a time; data wins unless a fetch has starved too long.
module slurm32_memory_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        instruction_request,
    input  logic [29:0] instruction_address,
    output logic        instruction_valid,
    output logic [31:0] instruction_in,
    output logic [29:0] instruction_address_in,
    input  logic        load_memory,
    input  logic        store_memory,
    input  logic [29:0] load_store_address,
    input  logic [31:0] memory_out,
    input  logic [3:0]  memory_mask,
    output logic        memory_request_successful,
    output logic [31:0] memory_in,
    output logic        memory_valid,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [29:0] mem_address,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic        mem_ready,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, WAIT_FETCH, WAIT_LOAD} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
    logic [29:0]      fetch_addr_q, fetch_addr_d;
    logic             instruction_valid_q, instruction_valid_d;
    logic             memory_valid_q, memory_valid_d;
    logic [31:0]      instruction_in_q, instruction_in_d;
    logic [31:0]      memory_in_q, memory_in_d;
    logic [29:0]      instruction_address_in_q, instruction_address_in_d;

    logic sel_data;
    logic sel_fetch;
    logic grant;

    // Source selection is only meaningful in IDLE and never while reset is held.
    always_comb begin
        sel_data  = 1'b0;
        sel_fetch = 1'b0;
        if (!RST && state_q == IDLE) begin
            sel_data  = (load_memory | store_memory) &&
                        ((starve_cnt_q < LIMIT) || !instruction_request);
            sel_fetch = !sel_data && instruction_request;
        end
    end

    assign mem_req                   = sel_data | sel_fetch;
    assign mem_wr                    = sel_data & store_memory;
    assign mem_address               = sel_data ? load_store_address : instruction_address;
    assign mem_wdata                 = memory_out;
    assign mem_wmask                 = mem_wr ? memory_mask : 4'hF;
    assign memory_request_successful = sel_data & mem_ready;
    assign grant                     = mem_req & mem_ready;

    always_comb begin
        state_d                  = state_q;
        starve_cnt_d             = starve_cnt_q;
        fetch_addr_d             = fetch_addr_q;
        instruction_valid_d      = 1'b0;
        memory_valid_d           = 1'b0;
        instruction_in_d         = instruction_in_q;
        memory_in_d              = memory_in_q;
        instruction_address_in_d = instruction_address_in_q;

        case (state_q)
            IDLE: begin
                if (grant && sel_fetch) begin
                    fetch_addr_d = instruction_address;
                    state_d      = WAIT_FETCH;
                end else if (grant && !store_memory) begin
                    state_d = WAIT_LOAD;
                end
            end
            WAIT_FETCH: begin
                if (mem_rvalid) begin
                    instruction_in_d         = mem_rdata;
                    instruction_address_in_d = fetch_addr_q;
                    instruction_valid_d      = 1'b1;
                    state_d                  = IDLE;
                end
            end
            WAIT_LOAD: begin
                if (mem_rvalid) begin
                    memory_in_d    = mem_rdata;
                    memory_valid_d = 1'b1;
                    state_d        = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Counts data grants taken while a fetch waits; saturates so the fetch wins next.
        if (!instruction_request || (grant && sel_fetch)) begin
            starve_cnt_d = '0;
        end else if (grant && sel_data && starve_cnt_q < LIMIT) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q                  <= IDLE;
            starve_cnt_q             <= '0;
            instruction_valid_q      <= 1'b0;
            memory_valid_q           <= 1'b0;
            instruction_in_q         <= '0;
            memory_in_q              <= '0;
            instruction_address_in_q <= '0;
        end else begin
            state_q                  <= state_d;
            starve_cnt_q             <= starve_cnt_d;
            instruction_valid_q      <= instruction_valid_d;
            memory_valid_q           <= memory_valid_d;
            instruction_in_q         <= instruction_in_d;
            memory_in_q              <= memory_in_d;
            instruction_address_in_q <= instruction_address_in_d;
        end
    end

    // The latched fetch address is only read in WAIT_FETCH, so it needs no reset.
    always_ff @(posedge CLK) begin
        fetch_addr_q <= fetch_addr_d;
    end

    assign instruction_valid      = instruction_valid_q;
    assign memory_valid           = memory_valid_q;
    assign instruction_in         = instruction_in_q;
    assign memory_in              = memory_in_q;
    assign instruction_address_in = instruction_address_in_q;

endmodule

// File: tb/tb_slurm32_memory_arbiter.sv
// Self-checking bench for slurm32_memory_arbiter: memory responder model plus
// fetch/load scoreboards filled by the stimulus and drained by the output monitor.
module tb_slurm32_memory_arbiter;

    logic        CLK = 1'b0;
    logic        RST;
    logic        instruction_request;
    logic [29:0] instruction_address;
    logic        instruction_valid;
    logic [31:0] instruction_in;
    logic [29:0] instruction_address_in;
    logic        load_memory;
    logic        store_memory;
    logic [29:0] load_store_address;
    logic [31:0] memory_out;
    logic [3:0]  memory_mask;
    logic        memory_request_successful;
    logic [31:0] memory_in;
    logic        memory_valid;
    logic        mem_req;
    logic        mem_wr;
    logic [29:0] mem_address;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_ready;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;

    slurm32_memory_arbiter #(.STARVE_LIMIT(4)) dut (
        .CLK                       (CLK),
        .RST                       (RST),
        .instruction_request       (instruction_request),
        .instruction_address       (instruction_address),
        .instruction_valid         (instruction_valid),
        .instruction_in            (instruction_in),
        .instruction_address_in    (instruction_address_in),
        .load_memory               (load_memory),
        .store_memory              (store_memory),
        .load_store_address        (load_store_address),
        .memory_out                (memory_out),
        .memory_mask               (memory_mask),
        .memory_request_successful (memory_request_successful),
        .memory_in                 (memory_in),
        .memory_valid              (memory_valid),
        .mem_req                   (mem_req),
        .mem_wr                    (mem_wr),
        .mem_address               (mem_address),
        .mem_wdata                 (mem_wdata),
        .mem_wmask                 (mem_wmask),
        .mem_ready                 (mem_ready),
        .mem_rvalid                (mem_rvalid),
        .mem_rdata                 (mem_rdata)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [29:0] a;
        logic [31:0] d;
    } fexp_t;

    int          total = 0;
    int          bad = 0;
    int          icount = 0;
    int          mcount = 0;
    int          lat = 2;
    fexp_t       fq[$];
    logic [31:0] lq[$];
    fexp_t       fe;
    logic [31:0] le;
    logic [31:0] mem_m [logic [29:0]];
    logic [31:0] exp_m [logic [29:0]];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] dflt(input logic [29:0] a);
        return 32'hA500_0000 ^ {2'b00, a};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] m);
        logic [31:0] m32;
        m32 = {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
        return (old & ~m32) | (wd & m32);
    endfunction

    function automatic logic [31:0] rd_m(input logic [29:0] a);
        return mem_m.exists(a) ? mem_m[a] : dflt(a);
    endfunction

    function automatic logic [31:0] rd_exp(input logic [29:0] a);
        return exp_m.exists(a) ? exp_m[a] : dflt(a);
    endfunction

    // Memory port model: accepts on negedge, returns read data lat cycles later.
    logic        pend = 1'b0;
    int          cd = 0;
    logic [29:0] paddr;
    always @(negedge CLK) begin
        mem_rvalid = 1'b0;
        if (pend) begin
            cd--;
            if (cd == 0) begin
                mem_rvalid = 1'b1;
                mem_rdata  = rd_m(paddr);
                pend       = 1'b0;
            end
        end
        if (mem_req && mem_ready) begin
            if (mem_wr) begin
                mem_m[mem_address] = merge(rd_m(mem_address), mem_wdata, mem_wmask);
            end else begin
                pend  = 1'b1;
                paddr = mem_address;
                cd    = lat;
            end
        end
    end

    logic piv = 1'b0;
    logic pmv = 1'b0;
    always @(negedge CLK) begin
        if (piv) chk("ivalid_pulse", 32'(instruction_valid), 32'd0);
        if (pmv) chk("mvalid_pulse", 32'(memory_valid), 32'd0);
        piv = instruction_valid;
        pmv = memory_valid;
        if (instruction_valid) begin
            icount++;
            if (fq.size() == 0) begin
                chk("ivalid_spurious", 32'd1, 32'd0);
            end else begin
                fe = fq.pop_front();
                chk("iaddr", {2'b00, instruction_address_in}, {2'b00, fe.a});
                chk("idata", instruction_in, fe.d);
            end
        end
        if (memory_valid) begin
            mcount++;
            if (lq.size() == 0) begin
                chk("mvalid_spurious", 32'd1, 32'd0);
            end else begin
                le = lq.pop_front();
                chk("ldata", memory_in, le);
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_i(input int old, input int bound);
        for (int k = 0; k < bound; k++) begin
            @(negedge CLK);
            #1;
            if (icount != old) return;
        end
        chk("ivalid_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_m(input int old, input int bound);
        for (int k = 0; k < bound; k++) begin
            @(negedge CLK);
            #1;
            if (mcount != old) return;
        end
        chk("mvalid_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_load(input logic [29:0] a);
        int old;
        old = mcount;
        step();
        load_memory        = 1'b1;
        load_store_address = a;
        lq.push_back(rd_exp(a));
        #1;
        chk("load_mrs", 32'(memory_request_successful), 32'd1);
        chk("load_wr", 32'(mem_wr), 32'd0);
        step();
        load_memory = 1'b0;
        wait_m(old, 20);
    endtask

    initial begin
        int          old;
        int          nst;
        logic        got_fetch;
        logic [29:0] sa;
        logic [31:0] sd;

        mem_m[30'h10] = 32'h3001_0003;
        exp_m[30'h10] = 32'h3001_0003;
        RST                 = 1'b1;
        instruction_request = 1'b1;
        instruction_address = 30'h7;
        load_memory         = 1'b1;
        store_memory        = 1'b0;
        load_store_address  = 30'h9;
        memory_out          = '0;
        memory_mask         = 4'h0;
        mem_ready           = 1'b1;
        repeat (3) step();
        #1;
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mrs", 32'(memory_request_successful), 32'd0);
        step();
        RST                 = 1'b0;
        instruction_request = 1'b0;
        load_memory         = 1'b0;
        #1;
        chk("rst_ivalid", 32'(instruction_valid), 32'd0);
        chk("rst_mvalid", 32'(memory_valid), 32'd0);
        chk("rst_iin", instruction_in, 32'd0);
        chk("rst_min", memory_in, 32'd0);
        chk("rst_iaddr", {2'b00, instruction_address_in}, 32'd0);
        chk("idle_no_req", 32'(mem_req), 32'd0);

        // single fetch, read data two cycles after accept
        old = icount;
        step();
        instruction_request = 1'b1;
        instruction_address = 30'h10;
        fq.push_back('{a: 30'h10, d: rd_exp(30'h10)});
        #1;
        chk("f_req", 32'(mem_req), 32'd1);
        chk("f_addr", {2'b00, mem_address}, 32'h10);
        chk("f_wr", 32'(mem_wr), 32'd0);
        chk("f_mask", 32'(mem_wmask), 32'hF);
        chk("f_mrs", 32'(memory_request_successful), 32'd0);
        step();
        instruction_request = 1'b0;
        #1;
        chk("f_wait_req", 32'(mem_req), 32'd0);
        wait_i(old, 20);
        @(negedge CLK);
        #1;
        chk("f_hold_data", instruction_in, 32'h3001_0003);
        chk("f_hold_addr", {2'b00, instruction_address_in}, 32'h10);

        // simultaneous fetch and load: load first, fetch once load data returns
        lat = 1;
        old = mcount;
        step();
        instruction_request = 1'b1;
        instruction_address = 30'h4;
        load_memory         = 1'b1;
        load_store_address  = 30'h20;
        lq.push_back(rd_exp(30'h20));
        fq.push_back('{a: 30'h4, d: rd_exp(30'h4)});
        #1;
        chk("sim_addr", {2'b00, mem_address}, 32'h20);
        chk("sim_mrs", 32'(memory_request_successful), 32'd1);
        step();
        load_memory = 1'b0;
        #1;
        chk("sim_wait_req", 32'(mem_req), 32'd0);
        wait_m(old, 20);
        chk("sim_fetch_req", 32'(mem_req), 32'd1);
        chk("sim_fetch_addr", {2'b00, mem_address}, 32'h4);
        chk("sim_fetch_mrs", 32'(memory_request_successful), 32'd0);
        old = icount;
        step();
        instruction_request = 1'b0;
        wait_i(old, 20);

        // masked store, then a load right after proves IDLE and the byte merge
        lat = 3;
        old = mcount;
        step();
        store_memory       = 1'b1;
        load_store_address = 30'h8;
        memory_out         = 32'hDEAD_BEEF;
        memory_mask        = 4'b0011;
        exp_m[30'h8] = merge(rd_exp(30'h8), 32'hDEAD_BEEF, 4'b0011);
        #1;
        chk("st_req", 32'(mem_req), 32'd1);
        chk("st_wr", 32'(mem_wr), 32'd1);
        chk("st_mask", 32'(mem_wmask), 32'h3);
        chk("st_wdata", mem_wdata, 32'hDEAD_BEEF);
        chk("st_mrs", 32'(memory_request_successful), 32'd1);
        step();
        store_memory = 1'b0;
        do_load(30'h8);
        chk("st_one_strobe", 32'(mcount), 32'(old + 1));

        // backpressure on a load
        old = mcount;
        step();
        mem_ready          = 1'b0;
        load_memory        = 1'b1;
        load_store_address = 30'h33;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("bp_req", 32'(mem_req), 32'd1);
            chk("bp_addr", {2'b00, mem_address}, 32'h33);
            chk("bp_mrs", 32'(memory_request_successful), 32'd0);
            step();
        end
        mem_ready = 1'b1;
        lq.push_back(rd_exp(30'h33));
        #1;
        chk("bp_ready_mrs", 32'(memory_request_successful), 32'd1);
        step();
        load_memory = 1'b0;
        wait_m(old, 20);

        // starvation: continuous stores with a fetch pending
        lat = 2;
        old = icount;
        nst = 0;
        got_fetch = 1'b0;
        sa = 30'h100;
        sd = $urandom;
        step();
        instruction_request = 1'b1;
        instruction_address = 30'h44;
        fq.push_back('{a: 30'h44, d: rd_exp(30'h44)});
        store_memory       = 1'b1;
        memory_mask        = 4'hF;
        load_store_address = sa;
        memory_out         = sd;
        for (int c = 0; c < 12 && !got_fetch; c++) begin
            #1;
            if (memory_request_successful && mem_wr) begin
                exp_m[sa] = merge(rd_exp(sa), sd, 4'hF);
                nst++;
            end else if (mem_req && !mem_wr) begin
                got_fetch = 1'b1;
                chk("starve_faddr", {2'b00, mem_address}, 32'h44);
            end
            step();
            if (!got_fetch) begin
                sa = sa + 30'd1;
                sd = $urandom;
                load_store_address = sa;
                memory_out         = sd;
            end
        end
        chk("starve_nstore", 32'(nst), 32'd4);
        chk("starve_fetch", 32'(got_fetch), 32'd1);
        wait_i(old, 20);
        chk("starve_cnt_clr_req", 32'(mem_req), 32'd1);
        chk("starve_cnt_clr_wr", 32'(mem_wr), 32'd1);
        chk("starve_cnt_clr_mrs", 32'(memory_request_successful), 32'd1);
        exp_m[sa] = merge(rd_exp(sa), sd, 4'hF);
        step();
        store_memory        = 1'b0;
        instruction_request = 1'b0;
        do_load(30'h100);
        do_load(30'h104);

        // reset while a fetch is outstanding
        old = icount;
        step();
        instruction_request = 1'b1;
        instruction_address = 30'h50;
        #1;
        chk("rf_req", 32'(mem_req), 32'd1);
        step();
        instruction_request = 1'b0;
        RST                 = 1'b1;
        store_memory        = 1'b1;
        load_store_address  = 30'h60;
        #1;
        chk("rf_rst_req", 32'(mem_req), 32'd0);
        chk("rf_rst_mrs", 32'(memory_request_successful), 32'd0);
        step();
        RST          = 1'b0;
        store_memory = 1'b0;
        repeat (5) @(negedge CLK);
        #1;
        chk("rf_no_strobe", 32'(icount), 32'(old));
        chk("rf_ivalid", 32'(instruction_valid), 32'd0);
        chk("rf_iin_clr", instruction_in, 32'd0);
        chk("rf_iaddr_clr", {2'b00, instruction_address_in}, 32'd0);
        do_load(30'h60);

        repeat (3) step();
        chk("fq_empty", 32'(fq.size()), 32'd0);
        chk("lq_empty", 32'(lq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/slurm32_memory_arbiter.md
SLURM32_MEMORY_ARBITER -- requirements
Module: slurm32_memory_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, meaning the number of consecutive data grants allowed while a fetch is pending.
REQ-002 SHALL have CLK  in  1  system clock; all state updates on the rising edge.
REQ-003 SHALL have RST  in  1  reset; synchronous, active-high.
REQ-004 SHALL have instruction_request  in  1  fetch request from the pipeline.
REQ-005 SHALL have instruction_address  in  30  fetch word address.
REQ-006 SHALL have instruction_valid  out  1  one-cycle fetch-data strobe.
REQ-007 SHALL have instruction_in  out  32  fetched word.
REQ-008 SHALL have instruction_address_in  out  30  address of the fetched word.
REQ-009 SHALL have load_memory  in  1  data load request from execute.
REQ-010 SHALL have store_memory  in  1  data store request from execute.
REQ-011 SHALL have load_store_address  in  30  data word address.
REQ-012 SHALL have memory_out  in  32  store data.
REQ-013 SHALL have memory_mask  in  4  byte-lane write mask.
REQ-014 SHALL have memory_request_successful  out  1  data request accepted this cycle.
REQ-015 SHALL have memory_in  out  32  load data.
REQ-016 SHALL have memory_valid  out  1  one-cycle load-data strobe.
REQ-017 SHALL have mem_req  out  1  request to the shared memory port.
REQ-018 SHALL have mem_wr  out  1  1 = write, 0 = read.
REQ-019 SHALL have mem_address  out  30  port word address.
REQ-020 SHALL have mem_wdata  out  32  port write data.
REQ-021 SHALL have mem_wmask  out  4  port byte mask.
REQ-022 SHALL have mem_ready  in  1  port accepts the request this cycle.
REQ-023 SHALL have mem_rvalid  in  1  read data valid.
REQ-024 SHALL have mem_rdata  in  32  read data.

Function
REQ-025 SHALL implement FSM states IDLE, WAIT_FETCH, and WAIT_LOAD, with at most one outstanding port transaction.
REQ-026 SHALL, in IDLE, select data when (load_memory|store_memory) and (starve_cnt < STARVE_LIMIT or !instruction_request); otherwise select fetch if instruction_request.
REQ-027 SHALL, in IDLE with a selection, drive mem_req=1 combinationally, with mem_address, mem_wr, mem_wdata, and mem_wmask taken from the selected source; mem_wr=store_memory only for data, mem_wmask=4'hF for reads.
REQ-028 SHALL treat load_memory and store_memory both high as a store.
REQ-029 SHALL hold mem_req=0 outside IDLE and when nothing is selected.
REQ-030 SHALL assert memory_request_successful combinationally only when mem_req & mem_ready & data selected; it is 0 in all other cycles.
REQ-031 SHALL, on an accepted store, return to IDLE with no response expected.
REQ-032 SHALL, on an accepted load, enter WAIT_LOAD.
REQ-033 SHALL, on an accepted fetch, latch instruction_address and enter WAIT_FETCH.
REQ-034 SHALL, on mem_ready=0, change no state and let the requester hold its signals.
REQ-035 SHALL, on mem_rvalid in WAIT_FETCH, register instruction_in<=mem_rdata, instruction_address_in<=latched address, and instruction_valid<=1 for exactly one cycle, then return to IDLE.
REQ-036 SHALL, on mem_rvalid in WAIT_LOAD, register memory_in<=mem_rdata and memory_valid<=1 for exactly one cycle, then return to IDLE.
REQ-037 SHALL ignore mem_rvalid in IDLE.
REQ-038 SHALL give a minimum read latency of request-accept cycle + mem_rvalid cycle + 1 registered output cycle, and allow a new request in the cycle after return to IDLE.
REQ-039 SHALL increment starve_cnt (saturating at STARVE_LIMIT) on each accepted data grant while instruction_request=1.
REQ-040 SHALL clear starve_cnt on any accepted fetch or when instruction_request=0.
REQ-041 SHALL guarantee a fetch within STARVE_LIMIT+1 grants under continuous data traffic.
REQ-042 SHALL hold instruction_in, memory_in, and instruction_address_in between strobes.

Reset
REQ-043 SHALL, with RST=1 at a clock edge, force state=IDLE, starve_cnt=0, instruction_valid=0, memory_valid=0, instruction_in=0, memory_in=0, and instruction_address_in=0.
REQ-044 SHALL, on reset mid-transaction, abandon the outstanding read, so a subsequent mem_rvalid produces no strobe.
REQ-045 SHALL force combinational outputs mem_req=0 and memory_request_successful=0 while RST=1.

Verification
REQ-046 SHALL verify single fetch: fetch 0x10, mem_ready=1, mem_rvalid 2 cycles later with 0x30010003 -> one-cycle instruction_valid, instruction_in=0x30010003, instruction_address_in=0x10.
REQ-047 SHALL verify simultaneous requests: fetch 0x4 with load 0x20 -> load issued first, memory_request_successful=1 that cycle, fetch issued after load data returns.
REQ-048 SHALL verify store: store 0x8, data 0xDEADBEEF, mask 4'b0011 -> mem_wr=1, mem_wmask=0011, memory_request_successful=1, no memory_valid, IDLE next cycle.
REQ-049 SHALL verify starvation: continuous stores with fetch pending, STARVE_LIMIT=4 -> exactly 4 stores accepted, then fetch granted, starve_cnt=0.
REQ-050 SHALL verify backpressure: mem_ready=0 for 3 cycles on a load -> mem_req held with constant address, memory_request_successful=0 until the ready cycle.
REQ-051 SHALL verify reset mid-operation: RST during WAIT_FETCH, then mem_rvalid -> instruction_valid stays 0, state IDLE.
